ifetch_unit: RTL and testbench

- Multi-cycle instruction fetch unit. It is the producer side of the control-decoder interface: it fetches from instruction memory and presents the opcode/funct fields to the decoder.
- It consumes the decoder's jump indication and the datapath's branch outcome to form the next PC.
- It sits between instruction memory and the decoder/datapath, and holds the PC and IR for the processor.

---
 rtl/ifetch_unit.sv | 110 +++++++++++
 tb/tb_ifetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Purpose : multi-cycle instruction fetch; holds PC/IR and forms the next PC from jump/branch results.
// Latency : at least 2 cycles per instruction (1 fetch cycle when imem acks at once + 1 issue cycle).
// Backpres: waits in fetch for imem_ack (halts after TIMEOUT cycles); holds issue until exec_done.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   imem_req/addr/ack/rdata instruction memory request/response
//   pc, instr               address and contents of the instruction being executed
//   opcode, funct           instr[31:26] / instr[5:0] for the decoder
//   instr_valid             instr is being executed (issue state)
//   exec_done, jump_en,
//   branch_taken            datapath completion and next-PC selection, sampled together
//   fetch_err               sticky memory-timeout flag
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        jump_en,
  input  logic        branch_taken,
  output logic        fetch_err
);

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic [31:0]   w_p4;
  logic [31:0]   w_jmp;
  logic [31:0]   w_br;
  logic [31:0]   w_npc;

  // Next-PC candidates; jump outranks branch.
  assign w_p4  = r_pc + 32'd4;
  assign w_jmp = {w_p4[31:28], r_instr[25:0], 2'b00};
  assign w_br  = w_p4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_npc = jump_en      ? w_jmp :
                 branch_taken ? w_br  : w_p4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_instr <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_cnt   <= '0;
            r_state <= S_ISSUE;
          end else if (r_cnt == CNT_MAX) begin
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_ISSUE: begin
          if (exec_done) begin
            r_pc    <= {w_npc[31:2], 2'b00};
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          // Only reset leaves this state.
          r_err <= 1'b1;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  // The request is gated by rst_n so nothing is issued during a reset cycle.
  assign imem_req    = (r_state == S_FETCH) && rst_n;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign funct       = r_instr[5:0];
  assign instr_valid = (r_state == S_ISSUE);
  assign fetch_err   = r_err;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        exec_done = 1'b0;
  logic        jump_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        fetch_err;

  ifetch_unit #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .instr        (instr),
    .opcode       (opcode),
    .funct        (funct),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .jump_en      (jump_en),
    .branch_taken (branch_taken),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] cur, input logic [31:0] ins,
                                            input logic j, input logic b);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = cur + 32'd4;
    off = 32'($signed(ins[15:0])) * 32'd4;
    if (j)      return (p4 & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
    else if (b) return p4 + off;
    else        return p4;
  endfunction

  // Starts at a negedge in fetch; ends at the first negedge of issue.
  task automatic do_fetch(input logic [31:0] data, input int dly);
    exp_t e;
    for (int i = 0; i <= dly; i++) begin
      chk("req_f", 32'(imem_req), 32'd1);
      chk("addr_f", imem_addr, m_pc);
      chk("valid_f", 32'(instr_valid), 32'd0);
      if (i == dly) begin
        imem_ack   = 1'b1;
        imem_rdata = data;
        exec_done  = 1'b0;
        sb_q.push_back('{pc: m_pc, instr: data});
      end else begin
        // exec_done during fetch must not move the PC.
        exec_done = 1'b1;
        jump_en   = 1'b1;
      end
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      exec_done  = 1'b0;
      jump_en    = 1'b0;
    end
    chk("valid_rise", 32'(instr_valid), 32'd1);
    chk("req_i", 32'(imem_req), 32'd0);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("pc_i", pc, e.pc);
      chk("instr_i", instr, e.instr);
      chk("opcode", 32'(opcode), 32'(e.instr[31:26]));
      chk("funct", 32'(funct), 32'(e.instr[5:0]));
      m_instr = e.instr;
    end
  endtask

  task automatic do_exec(input int dly, input logic j, input logic b, input logic stray);
    for (int k = 0; k <= dly; k++) begin
      chk("valid_i", 32'(instr_valid), 32'd1);
      chk("instr_hold", instr, m_instr);
      chk("pc_hold", pc, m_pc);
      chk("req_hold", 32'(imem_req), 32'd0);
      if (k == dly) begin
        exec_done    = 1'b1;
        jump_en      = j;
        branch_taken = b;
        m_pc         = model_npc(m_pc, m_instr, j, b);
      end else if (stray) begin
        imem_ack     = 1'b1;
        imem_rdata   = ~m_instr;
        jump_en      = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      exec_done    = 1'b0;
      imem_ack     = 1'b0;
      jump_en      = 1'b0;
      branch_taken = 1'b0;
    end
    chk("valid_drop", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);

    rst_n = 1'b1;
    #1;
    m_pc = 32'h0000_3000;
    chk("addr0", imem_addr, 32'h0000_3000);
    for (int n = 0; n < 2; n++) begin
      do_fetch(32'h0, 0);
      do_exec(0, 1'b0, 1'b0, 1'b0);
    end
    chk("addr3008", imem_addr, 32'h0000_3008);
    chk("err_seq", 32'(fetch_err), 32'd0);

    // Backward branch taken, then not taken.
    do_fetch(32'h1000_FFFE, 0);
    do_exec(0, 1'b0, 1'b1, 1'b0);
    chk("br_back", imem_addr, 32'h0000_3004);
    do_fetch(32'h0, 0);
    do_exec(0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h1000_FFFE, 0);
    do_exec(0, 1'b0, 1'b0, 1'b0);
    chk("br_nt", imem_addr, 32'h0000_300C);
    do_fetch(32'h0, 0);
    do_exec(0, 1'b0, 1'b0, 1'b0);

    // Jump wins over branch.
    chk("addr3010", imem_addr, 32'h0000_3010);
    do_fetch(32'h0800_0C40, 0);
    do_exec(0, 1'b1, 1'b1, 1'b0);
    chk("jmp", imem_addr, 32'h0000_3100);

    // Stalled memory (6 request cycles) and stalled execute with stray acks.
    do_fetch(32'h1234_5678, 5);
    do_exec(10, 1'b0, 1'b0, 1'b1);
    chk("stall_pc", imem_addr, 32'h0000_3104);

    for (int n = 0; n < 20; n++) begin
      do_fetch($urandom, $urandom_range(0, 3));
      do_exec($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Timeout: 16 unacked request cycles, then halt.
    for (int i = 0; i < 16; i++) begin
      chk("to_req", 32'(imem_req), 32'd1);
      chk("to_addr", imem_addr, m_pc);
      chk("to_err", 32'(fetch_err), 32'd0);
      @(negedge clk);
    end
    chk("halt_err", 32'(fetch_err), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      exec_done  = 1'b1;
      jump_en    = 1'b1;
      @(negedge clk);
      chk("halt_req2", 32'(imem_req), 32'd0);
      chk("halt_err2", 32'(fetch_err), 32'd1);
      chk("halt_valid2", 32'(instr_valid), 32'd0);
      chk("halt_pc", pc, m_pc);
    end
    imem_ack  = 1'b0;
    exec_done = 1'b0;
    jump_en   = 1'b0;

    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_err", 32'(fetch_err), 32'd0);
    chk("rst2_pc", pc, 32'h0000_3000);
    rst_n = 1'b1;
    #1;
    m_pc = 32'h0000_3000;

    // Reset while issuing at 0x3020, with exec_done in the same cycle.
    for (int n = 0; n < 8; n++) begin
      do_fetch($urandom, 0);
      do_exec(0, 1'b0, 1'b0, 1'b0);
    end
    chk("addr3020", imem_addr, 32'h0000_3020);
    do_fetch(32'hCAFE_F00D, 1);
    rst_n     = 1'b0;
    exec_done = 1'b1;
    jump_en   = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    jump_en   = 1'b0;
    chk("mid_valid", 32'(instr_valid), 32'd0);
    chk("mid_pc", pc, 32'h0000_3000);
    chk("mid_instr", instr, 32'h0);
    chk("mid_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    #1;
    m_pc = 32'h0000_3000;
    chk("post_addr", imem_addr, 32'h0000_3000);
    do_fetch(32'h0, 0);
    do_exec(0, 1'b0, 1'b0, 1'b0);
    chk("post_next", imem_addr, 32'h0000_3004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
